seq_divider: RTL and testbench

- Multi-cycle signed 32-bit divider for the Mini-SRC datapath: the inverse of the combinational Booth multiplier.
- Serves the DIV instruction. The quotient goes to LO and the remainder goes to HI.
- Iterative restoring algorithm on operand magnitudes, one quotient bit per clock, with sign correction at the end.
- The control unit launches it with a start/busy/done handshake.

---
 rtl/mini_src_div_pkg.sv | 16 +
 rtl/div_step.sv | 26 ++
 rtl/seq_divider.sv | 129 ++++++++++++
 tb/tb_seq_divider.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mini_src_div_pkg.sv
// Shared definitions for the Mini-SRC sequential divider: width, FSM states
// and the quotient reported when dividing by zero.
package mini_src_div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    ITER  = 3'd2,
    FIX   = 3'd3,
    DONE  = 3'd4
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step on magnitudes: shift {A,Q} left, trial-subtract
// the divisor from A, keep the difference and set Q[0] when it did not borrow.
module div_step
  import mini_src_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [2*WIDTH:0] i_aq,
  input  logic [WIDTH-1:0] i_dmag,
  output logic [2*WIDTH:0] o_aq
);

  logic [2*WIDTH:0] w_sh;
  logic [WIDTH:0]   w_a;
  logic [WIDTH:0]   w_t;
  logic             w_ge;

  // A stays below |divisor| between steps, so its top bit is always zero
  // before the shift and nothing is lost off the left end.
  assign w_sh = {i_aq[2*WIDTH-1:0], 1'b0};
  assign w_a  = w_sh[2*WIDTH:WIDTH];
  assign w_ge = (w_a >= {1'b0, i_dmag});
  assign w_t  = w_a - {1'b0, i_dmag};
  assign o_aq = w_ge ? {w_t, w_sh[WIDTH-1:1], 1'b1} : w_sh;

endmodule

// File: rtl/seq_divider.sv
// Iterative signed divider: magnitudes divided one bit per clock, signs fixed
// at the end; quotient to LO, remainder (sign of dividend) to HI.
module seq_divider
  import mini_src_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       r_state;
  div_state_t       w_next;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic             r_sign_q;
  logic             r_sign_r;
  logic [2*WIDTH:0] r_aq;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [2*WIDTH:0] w_aq_next;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_a;

  // Negating -2^(WIDTH-1) wraps to itself, which read unsigned is the
  // correct magnitude.
  assign w_dvd_mag = r_dvd[WIDTH-1] ? -r_dvd : r_dvd;
  assign w_dvs_mag = r_dvs[WIDTH-1] ? -r_dvs : r_dvs;
  assign w_q       = r_aq[WIDTH-1:0];
  assign w_a       = r_aq[2*WIDTH-1:WIDTH];

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_aq   (r_aq),
    .i_dmag (w_dvs_mag),
    .o_aq   (w_aq_next)
  );

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE:  if (start) w_next = SETUP;
      SETUP: begin
        busy   = 1'b1;
        w_next = (r_dvs == '0) ? DONE : ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (r_cnt == '0) w_next = FIX;
      end
      FIX: begin
        busy   = 1'b1;
        w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_aq     <= '0;
      r_cnt    <= '0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_dbz    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_dvd    <= dividend;
            r_dvs    <= divisor;
            r_sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_sign_r <= dividend[WIDTH-1];
            r_dbz    <= 1'b0;
          end
        end
        SETUP: begin
          r_aq  <= {{(WIDTH+1){1'b0}}, w_dvd_mag};
          r_cnt <= CW'(WIDTH-1);
          if (r_dvs == '0) begin
            r_quot <= DIV0_QUOTIENT;
            r_rem  <= r_dvd;
            r_dbz  <= 1'b1;
          end
        end
        ITER: begin
          r_aq  <= w_aq_next;
          r_cnt <= r_cnt - CW'(1);
        end
        FIX: begin
          r_quot <= r_sign_q ? -w_q : w_q;
          r_rem  <= r_sign_r ? -w_a : w_a;
        end
        default: ;
      endcase
    end
  end

  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed sign/edge cases, divide by
// zero, ignored starts, back-to-back, mid-operation reset and random operands.
module tb_seq_divider;

  localparam int W        = 32;
  localparam int LAT_NORM = W + 2;  // accepting edge index -> done edge index
  localparam int LAT_DZ   = 1;
  localparam int TMO      = 200;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dvd = '0;
  logic [W-1:0] dvs = '0;
  logic         busy, done, dz;
  logic [W-1:0] quot, rem;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clock       (clk),
    .reset       (rst),
    .start       (start),
    .dividend    (dvd),
    .divisor     (dvs),
    .busy        (busy),
    .done        (done),
    .quotient    (quot),
    .remainder   (rem),
    .div_by_zero (dz)
  );

  // Truncating signed division, done in 64-bit arithmetic.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      q = 32'hFFFFFFFF;
      r = a;
      z = 1'b1;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      z = 1'b0;
    end
  endfunction

  // Called at a falling edge while IDLE; returns at the falling edge of the
  // done cycle (or after the timeout). lat = edges from acceptance to done.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic z, output int lat, output int bcnt,
                       output logic bdone);
    dvd = a;
    dvs = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    bcnt = 0;
    while (done !== 1'b1 && lat < TMO) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    q = quot;
    r = rem;
    z = dz;
    bdone = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    nchk++;
    if ({busy, done, dz} !== 3'b000) begin
      nerr++;
      $display("FAIL reset_flags busy/done/dz=%b exp=000", {busy, done, dz});
    end
    nchk++;
    if (quot !== '0) begin
      nerr++;
      $display("FAIL reset_quot got=%h exp=0", quot);
    end
    nchk++;
    if (rem !== '0) begin
      nerr++;
      $display("FAIL reset_rem got=%h exp=0", rem);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[8] = '{32'd100, -32'sd100, 32'd100, -32'sd100,
                            32'h80000000, 32'd5, 32'h80000000, 32'h7FFFFFFF};
    logic [W-1:0] tb[8] = '{32'd7, 32'd7, -32'sd7, -32'sd7,
                            32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'd1};
    logic [W-1:0] q, r, eq, er;
    logic z, ez, bd;
    int lat, bc;
    for (int i = 0; i < 8; i++) begin
      model(ta[i], tb[i], eq, er, ez);
      do_op(ta[i], tb[i], q, r, z, lat, bc, bd);
      nchk++;
      if (q !== eq || r !== er || z !== ez) begin
        nerr++;
        $display("FAIL directed[%0d] q=%h r=%h dz=%b exp q=%h r=%h dz=%b",
                 i, q, r, z, eq, er, ez);
      end
      nchk++;
      if (lat !== LAT_NORM || bc !== LAT_NORM || bd !== 1'b0) begin
        nerr++;
        $display("FAIL directed_timing[%0d] lat=%0d busy_cycles=%0d busy_at_done=%b exp %0d %0d 0",
                 i, lat, bc, bd, LAT_NORM, LAT_NORM);
      end
      @(negedge clk);
      nchk++;
      if (done !== 1'b0 || quot !== eq || rem !== er) begin
        nerr++;
        $display("FAIL directed_hold[%0d] done=%b q=%h r=%h exp done=0 q=%h r=%h",
                 i, done, quot, rem, eq, er);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] q, r;
    logic z, bd;
    int lat, bc;
    do_op(32'd1234, 32'd0, q, r, z, lat, bc, bd);
    nchk++;
    if (q !== 32'hFFFFFFFF || r !== 32'd1234 || z !== 1'b1 || lat !== LAT_DZ) begin
      nerr++;
      $display("FAIL div_zero q=%h r=%h dz=%b lat=%0d exp q=ffffffff r=000004d2 dz=1 lat=%0d",
               q, r, z, lat, LAT_DZ);
    end
    repeat (3) @(negedge clk);
    nchk++;
    if (dz !== 1'b1) begin
      nerr++;
      $display("FAIL div_zero_hold dz=%b exp=1", dz);
    end
    do_op(32'd50, 32'd5, q, r, z, lat, bc, bd);
    nchk++;
    if (q !== 32'd10 || r !== 32'd0 || z !== 1'b0) begin
      nerr++;
      $display("FAIL div_zero_clear q=%h r=%h dz=%b exp q=0000000a r=0 dz=0", q, r, z);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int k;
    dvd = 32'd100;
    dvs = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < TMO) begin
      if (k == 10) begin
        dvd = 32'd9;
        dvs = 32'd3;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    nchk++;
    if (quot !== 32'd14 || rem !== 32'd2 || k !== LAT_NORM) begin
      nerr++;
      $display("FAIL ignore_start q=%h r=%h lat=%0d exp q=0000000e r=2 lat=%0d",
               quot, rem, k, LAT_NORM);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] q, r;
    logic z, bd;
    int lat, bc;
    do_op(32'd100, 32'd7, q, r, z, lat, bc, bd);
    // start during the done cycle must be dropped
    dvd = 32'd8;
    dvs = 32'd0;
    start = 1'b1;
    @(negedge clk);
    nchk++;
    if (busy !== 1'b0 || dz !== 1'b0) begin
      nerr++;
      $display("FAIL start_in_done busy=%b dz=%b exp busy=0 dz=0", busy, dz);
    end
    do_op(32'd9, 32'd3, q, r, z, lat, bc, bd);
    nchk++;
    if (q !== 32'd3 || r !== 32'd0 || z !== 1'b0 || lat !== LAT_NORM) begin
      nerr++;
      $display("FAIL back_to_back q=%h r=%h dz=%b lat=%0d exp q=3 r=0 dz=0 lat=%0d",
               q, r, z, lat, LAT_NORM);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] q, r;
    logic z, bd;
    int lat, bc, ndone;
    dvd = 32'd100;
    dvs = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nchk++;
    if (busy !== 1'b0 || quot !== '0 || rem !== '0) begin
      nerr++;
      $display("FAIL reset_mid busy=%b q=%h r=%h exp busy=0 q=0 r=0", busy, quot, rem);
    end
    ndone = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    nchk++;
    if (ndone !== 0) begin
      nerr++;
      $display("FAIL reset_mid_no_done done_pulses=%0d exp=0", ndone);
    end
    do_op(32'd50, 32'd5, q, r, z, lat, bc, bd);
    nchk++;
    if (q !== 32'd10 || r !== 32'd0 || lat !== LAT_NORM) begin
      nerr++;
      $display("FAIL after_reset q=%h r=%h lat=%0d exp q=0000000a r=0 lat=%0d",
               q, r, lat, LAT_NORM);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [W-1:0] edge_v[6] = '{32'h80000000, 32'hFFFFFFFF, 32'h00000000,
                                32'h00000001, 32'h7FFFFFFF, 32'h80000001};
    logic [W-1:0] a, b, q, r, eq, er;
    logic z, ez, bd;
    int lat, bc, mode;
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 3);
      a = $urandom;
      b = $urandom;
      case (mode)
        1: begin
          b = 32'($urandom_range(1, 20));
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        2: a = 32'($urandom_range(0, 50));
        3: begin
          a = edge_v[$urandom_range(0, 5)];
          b = edge_v[$urandom_range(0, 5)];
        end
        default: ;
      endcase
      model(a, b, eq, er, ez);
      do_op(a, b, q, r, z, lat, bc, bd);
      nchk++;
      if (q !== eq || r !== er || z !== ez || lat !== (ez ? LAT_DZ : LAT_NORM)) begin
        nerr++;
        $display("FAIL random[%0d] %h/%h q=%h r=%h dz=%b lat=%0d exp q=%h r=%h dz=%b",
                 i, a, b, q, r, z, lat, eq, er, ez);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
